// File: rtl/debounced_input_pio.sv
// Debounced parallel input port with edge capture, interrupt mask and Avalon-MM slave.
// Define DEBOUNCED_INPUT_PIO_BOTH_EDGES_EN to capture falling as well as rising stable edges.
module debounced_input_pio #(
  parameter int WIDTH      = 4,
  parameter int DB_CYCLES  = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_export,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  localparam int             CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DB_CYCLES - 1);
  // Synchronisers reset to the idle pin level so the inverted sync value starts at 0
  localparam logic [WIDTH-1:0] SYNC_IDLE = {WIDTH{ACTIVE_LOW}};

  logic [WIDTH-1:0] sync1, sync2, sync_val;
  logic [WIDTH-1:0] stable, stable_next;
  logic [WIDTH-1:0] edgecapture, edge_event, edge_clear, edge_next;
  logic [WIDTH-1:0] irqmask, wr_bits;
  logic [CW-1:0]    cnt [WIDTH];
  logic [31:0]      rd_mux;

  assign sync_val = ACTIVE_LOW ? ~sync2 : sync2;
  assign wr_bits  = avs_writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_unused_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^avs_writedata[31:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= SYNC_IDLE;
      sync2 <= SYNC_IDLE;
    end else begin
      sync1 <= in_export;
      sync2 <= sync1;
    end
  end

  always_comb begin
    stable_next = stable;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_val[i] != stable[i] && cnt[i] == CNT_MAX)
        stable_next[i] = sync_val[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      stable <= stable_next;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_val[i] == stable[i] || cnt[i] == CNT_MAX)
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

`ifdef DEBOUNCED_INPUT_PIO_BOTH_EDGES_EN
  assign edge_event = stable_next ^ stable;
`else
  assign edge_event = stable_next & ~stable;
`endif

  // A new edge event wins over a simultaneous write-1-to-clear of the same bit
  assign edge_clear = (avs_write && avs_address == 2'd2) ? wr_bits : '0;
  assign edge_next  = (edgecapture & ~edge_clear) | edge_event;

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd1:    rd_mux[WIDTH-1:0] = irqmask;
      2'd2:    rd_mux[WIDTH-1:0] = edgecapture;
      default: rd_mux[WIDTH-1:0] = sync_val;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edgecapture  <= '0;
      irqmask      <= '0;
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      edgecapture <= edge_next;
      if (avs_write && avs_address == 2'd1)
        irqmask <= wr_bits;
      if (avs_read)
        avs_readdata <= rd_mux;
      irq <= |(edgecapture & irqmask);
    end
  end

endmodule

// File: tb/tb_debounced_input_pio.sv
// Self-checking bench for debounced_input_pio (WIDTH=4, DB_CYCLES=4, ACTIVE_LOW=1):
// directed scenarios followed by random pins and bus traffic against a behavioural model.
module tb_debounced_input_pio;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  in_export = 4'hF;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        irq;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0]  cur_pins = 4'hF;
  logic [31:0] rd_val;

  // Behavioural model state
  logic [3:0]    m_pipe0, m_pipe1, m_stable, m_edge, m_mask;
  logic          m_irq;
  logic [31:0]   m_rdata;
  logic [DB-1:0] m_win [4];
  int            m_since [4];

  debounced_input_pio #(.WIDTH(4), .DB_CYCLES(DB), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .in_export(in_export),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_stable};
      2'd1:    return {28'b0, m_mask};
      2'd2:    return {28'b0, m_edge};
      default: return {28'b0, m_pipe1};
    endcase
  endfunction

  task automatic model_reset();
    m_pipe0 = '0; m_pipe1 = '0; m_stable = '0; m_edge = '0; m_mask = '0;
    m_irq = 1'b0; m_rdata = '0;
    for (int i = 0; i < 4; i++) begin m_win[i] = '0; m_since[i] = 0; end
  endtask

  // A channel accepts a new level once its last DB samples all differed from
  // the accepted level and all of them were taken after its previous change.
  task automatic model_edge(input logic [3:0] pins, input logic [1:0] a, input logic rd,
                            input logic wr, input logic [31:0] wd);
    logic [3:0] new_stable, ev, clr;
    logic       irq_new;
    new_stable = m_stable;
    for (int i = 0; i < 4; i++) begin
      m_win[i] = {m_win[i][DB-2:0], m_pipe1[i] != m_stable[i]};
      m_since[i]++;
      if (m_since[i] >= DB && (&m_win[i])) begin
        new_stable[i] = m_pipe1[i];
        m_since[i] = 0;
        m_win[i] = '0;
      end
    end
`ifdef DEBOUNCED_INPUT_PIO_BOTH_EDGES_EN
    ev = new_stable ^ m_stable;
`else
    ev = new_stable & ~m_stable;
`endif
    clr = (wr && a == 2'd2) ? wd[3:0] : 4'h0;
    irq_new = |(m_edge & m_mask);
    if (rd) m_rdata = m_reg(a);
    m_edge = (m_edge & ~clr) | ev;
    if (wr && a == 2'd1) m_mask = wd[3:0];
    m_stable = new_stable;
    m_pipe1 = m_pipe0;
    m_pipe0 = ~pins;
    m_irq = irq_new;
  endtask

  task automatic cycle(input logic [3:0] pins, input logic [1:0] a, input logic rd,
                       input logic wr, input logic [31:0] wd);
    in_export = pins; avs_address = a; avs_read = rd; avs_write = wr; avs_writedata = wd;
    @(posedge clk);
    model_edge(pins, a, rd, wr, wd);
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0;
    check("rdata", avs_readdata, m_rdata);
    check("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(cur_pins, 2'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    cycle(cur_pins, a, 1'b1, 1'b0, 32'h0);
    v = avs_readdata;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    cycle(cur_pins, a, 1'b0, 1'b1, d);
  endtask

  task automatic do_reset();
    in_export = cur_pins;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_rdata", avs_readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_rel;
    logic       rd, wr;
    logic [1:0] a;

    // Reset with keys released
    @(negedge clk);
    do_reset();
    idle(2);
    for (int r = 0; r < 4; r++) begin
      read_reg(2'(r), rd_val);
      check("rst_reg", rd_val, 32'h0);
    end

    // Press key 0: DATA changes at the sixth edge after the pins change
    cur_pins = 4'hE;
    for (int k = 1; k <= 8; k++) begin
      cycle(cur_pins, 2'd0, 1'b1, 1'b0, 32'h0);
      check("press_lat", avs_readdata, (k >= 7) ? 32'h1 : 32'h0);
    end
    read_reg(2'd2, rd_val);
    check("press_edge", rd_val, 32'h1);
    check("press_irq_masked", {31'b0, irq}, 32'h0);

    // Interrupt enable then clear
    write_reg(2'd1, 32'h1);
    check("irq_mask_lag", {31'b0, irq}, 32'h0);
    idle(1);
    check("irq_set", {31'b0, irq}, 32'h1);
    write_reg(2'd2, 32'h1);
    check("irq_clr_lag", {31'b0, irq}, 32'h1);
    idle(1);
    check("irq_clr", {31'b0, irq}, 32'h0);

    // Release key 0
    cur_pins = 4'hF;
    idle(8);
`ifdef DEBOUNCED_INPUT_PIO_BOTH_EDGES_EN
    exp_rel = 4'h1;
`else
    exp_rel = 4'h0;
`endif
    read_reg(2'd2, rd_val);
    check("release_edge", rd_val, {28'b0, exp_rel});
    read_reg(2'd0, rd_val);
    check("release_data", rd_val, 32'h0);
    write_reg(2'd2, 32'hF);
    idle(2);

    // Glitch of three cycles on key 0
    cur_pins = 4'hE;
    idle(3);
    cur_pins = 4'hF;
    idle(8);
    read_reg(2'd0, rd_val);
    check("glitch_data", rd_val, 32'h0);
    read_reg(2'd2, rd_val);
    check("glitch_edge", rd_val, 32'h0);

    // Clear of bit 1 on the same edge that captures it
    cur_pins = 4'hD;
    idle(5);
    write_reg(2'd2, 32'h2);
    read_reg(2'd2, rd_val);
    check("collision_edge", rd_val, 32'h2);
    cur_pins = 4'hF;
    idle(8);
    write_reg(2'd2, 32'hF);
    idle(2);

    // Reset in the middle of a debounce count
    cur_pins = 4'hE;
    idle(4);
    cur_pins = 4'hF;
    do_reset();
    idle(8);
    read_reg(2'd0, rd_val);
    check("midrst_data", rd_val, 32'h0);
    read_reg(2'd2, rd_val);
    check("midrst_edge", rd_val, 32'h0);
    read_reg(2'd1, rd_val);
    check("midrst_mask", rd_val, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);

    // Random pins and bus traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 4) == 0)
        cur_pins[$urandom_range(0, 3)] ^= 1'b1;
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 7) == 0);
      a  = 2'($urandom_range(0, 3));
      cycle(cur_pins, a, rd, wr, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
